ppu_oam_ctrl: RTL

Sequencer for the PPU sprite attribute memories. It turns CPU register accesses ($2102/$2103 OAMADD, $2104 OAMDATA, $2138 OAMDATAREAD) into write and read cycles on the 256×16 low OAM and the 32-byte high OAM (HOAM). It implements the low-table even/odd byte latch, address auto-increment, the VBlank address reload and sprite priority rotation. It sits between the CPU bus register decoder and the two dual-port OAM RAMs, and owns their CPU-side ports.

---
 rtl/ppu_oam_ctrl_pkg.sv | 19 +
 rtl/ppu_oam_ctrl_if.sv | 39 +++
 rtl/ppu_oam_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ppu_oam_ctrl_pkg.sv
// Shared PPU OAM definitions: register select encodings, sequencer states, address widths.
package ppu_oam_ctrl_pkg;

    localparam int unsigned OAM_WADDR_W = 8;
    localparam int unsigned HOAM_ADDR_W = 5;
    localparam int unsigned OAM_IADDR_W = 10;

    localparam logic [1:0] OAM_SEL_ADDL = 2'd0;
    localparam logic [1:0] OAM_SEL_ADDH = 2'd1;
    localparam logic [1:0] OAM_SEL_DATA = 2'd2;
    localparam logic [1:0] OAM_SEL_READ = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StRdMem,
        StRdOut
    } oam_state_e;

endpackage

// File: rtl/ppu_oam_ctrl_if.sv
// Bus bundle between the CPU register decoder / OAM RAMs (master) and the OAM sequencer (slave).
interface ppu_oam_ctrl_if;
    import ppu_oam_ctrl_pkg::*;

    logic                   reg_wr;
    logic                   reg_rd;
    logic [1:0]             reg_sel;
    logic [7:0]             reg_din;
    logic [7:0]             reg_dout;
    logic                   rd_valid;
    logic                   busy;
    logic                   vblank_start;
    logic                   force_blank;
    logic                   render_active;
    logic [OAM_WADDR_W-1:0] loam_addr;
    logic [15:0]            loam_din;
    logic                   loam_we;
    logic [15:0]            loam_q;
    logic [HOAM_ADDR_W-1:0] hoam_addr;
    logic [7:0]             hoam_din;
    logic                   hoam_we;
    logic [7:0]             hoam_q;
    logic [6:0]             first_sprite;

    modport master (
        output reg_wr, reg_rd, reg_sel, reg_din, vblank_start, force_blank, render_active,
        output loam_q, hoam_q,
        input  reg_dout, rd_valid, busy, loam_addr, loam_din, loam_we,
        input  hoam_addr, hoam_din, hoam_we, first_sprite
    );

    modport slave (
        input  reg_wr, reg_rd, reg_sel, reg_din, vblank_start, force_blank, render_active,
        input  loam_q, hoam_q,
        output reg_dout, rd_valid, busy, loam_addr, loam_din, loam_we,
        output hoam_addr, hoam_din, hoam_we, first_sprite
    );

endinterface

// File: rtl/ppu_oam_ctrl.sv
// OAM access sequencer: turns OAMADD/OAMDATA/OAMDATAREAD register accesses into low OAM
// (256x16) and high OAM (32x8) cycles, with even-byte latch, auto-increment, VBlank reload
// and sprite priority rotation. Define OAM_PRIO_ROTATE_EN to enable first_sprite rotation.
module ppu_oam_ctrl
    import ppu_oam_ctrl_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    ppu_oam_ctrl_if.slave bus
);

    oam_state_e             r_state, w_state_nxt;
    logic [OAM_IADDR_W-2:0] r_oamadd, w_oamadd_nxt;
    logic                   r_prio, w_prio_nxt;
    logic [OAM_IADDR_W-1:0] r_iaddr, w_iaddr_nxt;
    logic [7:0]             r_latch, w_latch_nxt;
    logic                   r_rd_hi, w_rd_hi_nxt;
    logic                   r_rd_odd, w_rd_odd_nxt;
    logic [OAM_WADDR_W-1:0] r_loam_addr, w_loam_addr_nxt;
    logic [15:0]            r_loam_din, w_loam_din_nxt;
    logic                   r_loam_we, w_loam_we_nxt;
    logic [HOAM_ADDR_W-1:0] r_hoam_addr, w_hoam_addr_nxt;
    logic [7:0]             r_hoam_din, w_hoam_din_nxt;
    logic                   r_hoam_we, w_hoam_we_nxt;
    logic [7:0]             r_dout, w_dout_nxt;
    logic                   r_rd_valid, w_rd_valid_nxt;

    logic w_idle, w_rd_acc, w_wr_acc, w_addr_wr, w_data_wr, w_reload, w_wr_en;
    logic [6:0] w_first_sprite;

    // Strobes are only taken while idle; misdirected strobes are dropped.
    assign w_idle    = (r_state == StIdle);
    assign w_rd_acc  = w_idle & bus.reg_rd & (bus.reg_sel == OAM_SEL_READ);
    assign w_wr_acc  = w_idle & bus.reg_wr & (bus.reg_sel != OAM_SEL_READ);
    assign w_addr_wr = w_wr_acc & ((bus.reg_sel == OAM_SEL_ADDL) | (bus.reg_sel == OAM_SEL_ADDH));
    assign w_data_wr = w_wr_acc & (bus.reg_sel == OAM_SEL_DATA);
    assign w_reload  = bus.vblank_start & ~bus.force_blank;
    assign w_wr_en   = ~bus.render_active;

    // Read sequencer next-state: address phase, capture phase, then back to idle.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_rd_acc) w_state_nxt = StRdMem;
            StRdMem: w_state_nxt = StRdOut;
            StRdOut: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath next values: address registers, byte latch, RAM port drive and read capture.
    always_comb begin
        w_oamadd_nxt    = r_oamadd;
        w_prio_nxt      = r_prio;
        w_iaddr_nxt     = r_iaddr;
        w_latch_nxt     = r_latch;
        w_rd_hi_nxt     = r_rd_hi;
        w_rd_odd_nxt    = r_rd_odd;
        w_loam_addr_nxt = r_loam_addr;
        w_loam_din_nxt  = r_loam_din;
        w_loam_we_nxt   = 1'b0;
        w_hoam_addr_nxt = r_hoam_addr;
        w_hoam_din_nxt  = r_hoam_din;
        w_hoam_we_nxt   = 1'b0;
        w_dout_nxt      = r_dout;
        w_rd_valid_nxt  = 1'b0;

        if (w_data_wr) begin
            if (!r_iaddr[OAM_IADDR_W-1]) begin
                if (!r_iaddr[0]) begin
                    w_latch_nxt = bus.reg_din;
                end else begin
                    w_loam_addr_nxt = r_iaddr[OAM_WADDR_W:1];
                    w_loam_din_nxt  = {bus.reg_din, r_latch};
                    w_loam_we_nxt   = w_wr_en;
                end
            end else begin
                // iaddr[8:5] are don't-care here: the 32-byte table mirrors.
                w_hoam_addr_nxt = r_iaddr[HOAM_ADDR_W-1:0];
                w_hoam_din_nxt  = bus.reg_din;
                w_hoam_we_nxt   = w_wr_en;
            end
        end

        if (w_rd_acc) begin
            w_rd_hi_nxt     = r_iaddr[OAM_IADDR_W-1];
            w_rd_odd_nxt    = r_iaddr[0];
            w_loam_addr_nxt = r_iaddr[OAM_WADDR_W:1];
            w_hoam_addr_nxt = r_iaddr[HOAM_ADDR_W-1:0];
        end

        if (r_state == StRdOut) begin
            w_rd_valid_nxt = 1'b1;
            if (r_rd_hi) begin
                w_dout_nxt = bus.hoam_q;
            end else if (r_rd_odd) begin
                w_dout_nxt = bus.loam_q[15:8];
            end else begin
                w_dout_nxt = bus.loam_q[7:0];
            end
        end

        // Priority: OAMADD write > VBlank reload > access increment.
        if (w_data_wr || w_rd_acc) begin
            w_iaddr_nxt = r_iaddr + 10'd1;
        end
        if (w_reload) begin
            w_iaddr_nxt = {r_oamadd, 1'b0};
        end
        if (w_addr_wr) begin
            if (bus.reg_sel == OAM_SEL_ADDL) begin
                w_oamadd_nxt[7:0] = bus.reg_din;
            end else begin
                w_oamadd_nxt[8] = bus.reg_din[0];
                w_prio_nxt      = bus.reg_din[7];
            end
            w_iaddr_nxt = {w_oamadd_nxt, 1'b0};
        end
    end

    // Datapath registers; reset also drops any pending write enable or read result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_oamadd    <= '0;
            r_prio      <= 1'b0;
            r_iaddr     <= '0;
            r_latch     <= '0;
            r_rd_hi     <= 1'b0;
            r_rd_odd    <= 1'b0;
            r_loam_addr <= '0;
            r_loam_din  <= '0;
            r_loam_we   <= 1'b0;
            r_hoam_addr <= '0;
            r_hoam_din  <= '0;
            r_hoam_we   <= 1'b0;
            r_dout      <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_oamadd    <= w_oamadd_nxt;
            r_prio      <= w_prio_nxt;
            r_iaddr     <= w_iaddr_nxt;
            r_latch     <= w_latch_nxt;
            r_rd_hi     <= w_rd_hi_nxt;
            r_rd_odd    <= w_rd_odd_nxt;
            r_loam_addr <= w_loam_addr_nxt;
            r_loam_din  <= w_loam_din_nxt;
            r_loam_we   <= w_loam_we_nxt;
            r_hoam_addr <= w_hoam_addr_nxt;
            r_hoam_din  <= w_hoam_din_nxt;
            r_hoam_we   <= w_hoam_we_nxt;
            r_dout      <= w_dout_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
        end
    end

`ifdef OAM_PRIO_ROTATE_EN
    assign w_first_sprite = r_prio ? r_oamadd[7:1] : 7'd0;
`else
    // prio is still recorded but does not steer sprite evaluation.
    assign w_first_sprite = {6'd0, r_prio & 1'b0};
`endif

    assign bus.reg_dout     = r_dout;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.busy         = ~w_idle | r_rd_valid;
    assign bus.loam_addr    = r_loam_addr;
    assign bus.loam_din     = r_loam_din;
    assign bus.loam_we      = r_loam_we;
    assign bus.hoam_addr    = r_hoam_addr;
    assign bus.hoam_din     = r_hoam_din;
    assign bus.hoam_we      = r_hoam_we;
    assign bus.first_sprite = w_first_sprite;

endmodule
